// File: rtl/bcd_serial_sequencer.sv
// Serial packed-BCD add/subtract sequencer: one decimal-corrected digit per clock,
// least significant digit first, with a registered inter-digit carry.
module bcd_serial_sequencer #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  zero
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            zero_q, zero_d;

  logic [3:0]      a_dig_s, b_dig_s, b_eff_s, digit_s;
  logic [4:0]      sum_s;
  logic            carry_nx_s;
  logic [W-1:0]    result_nx_s;

  // Single digit stage: nine's-complement B on subtract, then decimal correction.
  always_comb begin
    a_dig_s    = op_a_q[{idx_q, 2'b00} +: 4];
    b_dig_s    = op_b_q[{idx_q, 2'b00} +: 4];
    b_eff_s    = sub_q ? (4'd9 - b_dig_s) : b_dig_s;
    sum_s      = {1'b0, a_dig_s} + {1'b0, b_eff_s} + {4'b0000, carry_q};
    if (sum_s > 5'd9) begin
      digit_s    = sum_s[3:0] + 4'd6;
      carry_nx_s = 1'b1;
    end else begin
      digit_s    = sum_s[3:0];
      carry_nx_s = 1'b0;
    end
    result_nx_s = result_q;
    result_nx_s[{idx_q, 2'b00} +: 4] = digit_s;
  end

  // Next-state logic for the sequencer FSM and its datapath registers.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          op_a_d   = op_a;
          op_b_d   = op_b;
          sub_d    = sub;
          carry_d  = cin;
          idx_d    = {IDXW{1'b0}};
          result_d = {W{1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d = result_nx_s;
        carry_d  = carry_nx_s;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          cout_d  = carry_nx_s;
          zero_d  = (result_nx_s == {W{1'b0}});
        end else begin
          idx_d   = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_a_q   <= {W{1'b0}};
      op_b_q   <= {W{1'b0}};
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= {IDXW{1'b0}};
      result_q <= {W{1'b0}};
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bcd_serial_sequencer.sv
// Directed self-checking bench for bcd_serial_sequencer with DIGITS=2.
module tb_bcd_serial_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic       cin;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       zero;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_serial_sequencer #(.DIGITS(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .cin    (cin),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Wait for done after an accept edge; returns number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic c, input logic [7:0] exp_res,
                       input logic exp_cout, input logic exp_zero);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_busy_run"}, 32'(busy), 32'd1);
    check_eq({tag, "_res_clr"}, 32'(result), 32'h0);
    wait_done(n);
    check_eq({tag, "_latency"}, 32'(n), 32'd2);
    check_eq({tag, "_result"}, 32'(result), 32'(exp_res));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check_eq({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_result_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = 8'h00; op_b = 8'h00;
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'h0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("add45_38", 8'h45, 8'h38, 1'b0, 1'b0, 8'h83, 1'b0, 1'b0);
    do_op("add99_01", 8'h99, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Asynchronous reset in the first RUN cycle (cout/zero are 1 beforehand).
    @(negedge clk);
    op_a = 8'h45; op_b = 8'h38; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("arst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_result", 32'(result), 32'h0);
    check_eq("arst_cout", 32'(cout), 32'd0);
    check_eq("arst_zero", 32'(zero), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    check_eq("arst_no_done", 32'(pulses), 32'd0);
    do_op("post_rst", 8'h45, 8'h38, 1'b0, 1'b0, 8'h83, 1'b0, 1'b0);

    do_op("sub50_25", 8'h50, 8'h25, 1'b1, 1'b1, 8'h25, 1'b1, 1'b0);
    do_op("sub25_50", 8'h25, 8'h50, 1'b1, 1'b1, 8'h75, 1'b0, 1'b0);
    do_op("invalid", 8'hFF, 8'h00, 1'b0, 1'b0, 8'h65, 1'b1, 1'b0);
    do_op("add_cin", 8'h19, 8'h19, 1'b0, 1'b1, 8'h39, 1'b0, 1'b0);

    // start pulsed during RUN must be ignored.
    @(negedge clk);
    op_a = 8'h45; op_b = 8'h38; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    op_a = 8'h11; op_b = 8'h11; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ign_latency", 32'(n), 32'd2);
    check_eq("ign_result", 32'(result), 32'h83);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    check_eq("ign_single_done", 32'(pulses), 32'd0);

    // start held through DONE: back-to-back acceptance.
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op_a = 8'h07; op_b = 8'h05;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("b2b_done1", 32'(done), 32'd1);
    check_eq("b2b_busy1", 32'(busy), 32'd0);
    check_eq("b2b_result1", 32'(result), 32'h46);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b_reaccept_busy", 32'(busy), 32'd1);
    check_eq("b2b_reaccept_done", 32'(done), 32'd0);
    check_eq("b2b_reaccept_clr", 32'(result), 32'h0);
    wait_done(n);
    check_eq("b2b_spacing", 32'(n + 1), 32'd3);
    check_eq("b2b_result2", 32'(result), 32'h12);
    check_eq("b2b_cout2", 32'(cout), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
